// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state, default bus widths and timer register map
package apb_arb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam logic [7:0] TCR_ADDR = 8'h00;
   localparam logic [7:0] TDR_ADDR = 8'h01;
   localparam logic [7:0] TSR_ADDR = 8'h02;
endpackage

// File: rtl/apb_timer_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; the pointer names the port that wins a tie
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_take,
   output logic [1:0] gnt
);
   logic ptr_q, ptr_d;
   // a tie goes to the pointer's port, a lone request always wins
   always_comb begin
      gnt   = (&req) ? (ptr_q ? 2'b10 : 2'b01) : req;
      ptr_d = grant_take ? gnt[0] : ptr_q;
   end
   // after a grant to port i the other port gets priority
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end
endmodule

// File: rtl/apb_timer_arbiter.sv
// apb_timer_arbiter: two-port round-robin APB master in front of the timer register block
// APB_ARB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT+1 cycles without PREADY
module apb_timer_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);
   state_e            state_q, state_d;
   logic [1:0]        gnt, done_q;
   logic              take, timeout, err_d;
   logic              win_q, wr_q, psel_q, pen_q, err0_q, err1_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_d, rdata0_q, rdata1_q;

   rr_arb2 u_arb (
      .clk        (PCLK),
      .rst        (PRESET),
      .req        ({req1_valid, req0_valid}),
      .grant_take (take),
      .gnt        (gnt)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // ACCESS cycle counter, held at zero outside ACCESS so each entry starts fresh
   always_comb begin
      cnt_d   = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
      timeout = (state_q == ACCESS) && (cnt_q == CW'(TIMEOUT));
   end
   // counter register
   always_ff @(posedge PCLK) begin
      if (PRESET) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // next state plus the response captured when leaving ACCESS
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      rdata_d = '0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            take    = req0_valid | req1_valid;
            state_d = take ? SETUP : IDLE;
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (PREADY) begin
               state_d = RESP;
               rdata_d = wr_q ? '0 : PRDATA;
               err_d   = PSLVERR;
            end else if (timeout) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, latched request and registered APB / requester outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= IDLE;
         win_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         psel_q   <= 1'b0;
         pen_q    <= 1'b0;
         done_q   <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take) begin
            win_q   <= gnt[1];
            wr_q    <= gnt[1] ? req1_write : req0_write;
            addr_q  <= gnt[1] ? req1_addr  : req0_addr;
            wdata_q <= gnt[1] ? req1_wdata : req0_wdata;
         end
         psel_q   <= (state_d == SETUP) || (state_d == ACCESS);
         pen_q    <= (state_d == ACCESS);
         done_q   <= (state_d == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
         rdata0_q <= (state_d == RESP && !win_q) ? rdata_d : '0;
         rdata1_q <= (state_d == RESP &&  win_q) ? rdata_d : '0;
         err0_q   <= (state_d == RESP && !win_q) && err_d;
         err1_q   <= (state_d == RESP &&  win_q) && err_d;
      end
   end

   assign PSEL       = psel_q;
   assign PENABLE    = pen_q;
   assign PWRITE     = wr_q;
   assign PADDR      = addr_q;
   assign PWDATA     = wdata_q;
   assign req0_done  = done_q[0];
   assign req1_done  = done_q[1];
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;
   assign req0_err   = err0_q;
   assign req1_err   = err1_q;
endmodule

// File: tb/tb_apb_timer_arbiter.sv
// tb_apb_timer_arbiter: scoreboard bench with a register-file slave and a rule-level reference model
module tb_apb_timer_arbiter;
   import apb_arb_pkg::*;

   typedef struct {
      bit         port;
      logic [7:0] rdata;
      bit         err;
   } exp_t;

   logic       PCLK = 1'b0, PRESET = 1'b1;
   logic       req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
   logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
   logic       req0_done, req1_done, req0_err, req1_err;
   logic [7:0] req0_rdata, req1_rdata;
   logic       PSEL, PENABLE, PWRITE;
   logic [7:0] PADDR, PWDATA;
   logic [7:0] PRDATA = 0;
   logic       PREADY = 0, PSLVERR = 0;

   int   n_cmp = 0, n_bad = 0;
   exp_t exp_q[$];
   exp_t me;
   bit   ptr_m = 0;
   logic [7:0] mreg [3] = '{default: 8'h00};
   logic [7:0] smem [3] = '{default: 8'h00};
   bit   hold = 0, rand_waits = 0;
   int   waits = 0, wcnt = 0;

   apb_timer_arbiter dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   // slave: registers 0..2 are read/write, anything higher answers PSLVERR; junk while not ready
   always @(posedge PCLK) begin
      if (PRESET || !(PSEL && PENABLE) || PREADY) begin
         PREADY  <= 1'b0;
         PSLVERR <= 1'($urandom);
         PRDATA  <= 8'($urandom);
         wcnt    <= 0;
         if (PSEL && !PENABLE) waits <= rand_waits ? int'($urandom_range(0, 3)) : 0;
      end else if (!hold && wcnt >= waits) begin
         PREADY  <= 1'b1;
         PSLVERR <= (PADDR > 8'd2);
         PRDATA  <= (PADDR <= 8'd2 && !PWRITE) ? smem[PADDR[1:0]] : 8'h00;
         if (PWRITE && PADDR <= 8'd2) smem[PADDR[1:0]] <= PWDATA;
      end else begin
         PRDATA  <= 8'($urandom);
         PSLVERR <= 1'($urandom);
         wcnt    <= wcnt + 1;
      end
   end

   // monitor: every done pulse is matched against the oldest expected completion
   always @(negedge PCLK) begin
      if (!PRESET && (req0_done || req1_done)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", {30'b0, req1_done, req0_done}, 32'h0);
         end else begin
            me = exp_q.pop_front();
            chk("done_port", {30'b0, req1_done, req0_done}, me.port ? 32'h2 : 32'h1);
            chk("rdata", me.port ? req1_rdata : req0_rdata, me.rdata);
            chk("err", me.port ? req1_err : req0_err, me.err);
         end
      end
   end

   function automatic logic [7:0] rnd_addr();
      return ($urandom_range(0, 7) == 0) ? 8'(3 + $urandom_range(0, 4)) : 8'($urandom_range(0, 2));
   endfunction

   task automatic push_exp(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.port  = p;
      e.err   = (a > 8'd2);
      e.rdata = (!w && a <= 8'd2) ? mreg[a[1:0]] : 8'h00;
      if (w && a <= 8'd2) mreg[a[1:0]] = d;
      exp_q.push_back(e);
      ptr_m = !p;
   endtask

   task automatic do_reset(input int n);
      @(posedge PCLK); #1;
      PRESET = 1; req0_valid = 0; req1_valid = 0;
      repeat (n) @(posedge PCLK);
      #1 PRESET = 0;
      ptr_m = 0;
   endtask

   task automatic run_round(input bit v0, input bit v1,
                            input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                            input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                            input bit strict, output int lat);
      bit first, p0, p1;
      bit fw;
      logic [7:0] fa, fd;
      int cyc;
      first = (v0 && v1) ? ptr_m : v1;
      fw = first ? w1 : w0;
      fa = first ? a1 : a0;
      fd = first ? d1 : d0;
      push_exp(first, fw, fa, fd);
      if (v0 && v1) push_exp(!first, first ? w0 : w1, first ? a0 : a1, first ? d0 : d1);
      @(posedge PCLK); #1;
      req0_write = w0; req0_addr = a0; req0_wdata = d0; req0_valid = v0;
      req1_write = w1; req1_addr = a1; req1_wdata = d1; req1_valid = v1;
      p0 = v0; p1 = v1; cyc = 0; lat = -1;
      while ((p0 || p1) && cyc < 300) begin
         @(negedge PCLK);
         if (strict && cyc <= 4) begin
            chk($sformatf("psel_c%0d", cyc), PSEL, (cyc >= 1 && cyc <= 3));
            chk($sformatf("penable_c%0d", cyc), PENABLE, (cyc >= 2 && cyc <= 3));
            if (cyc == 2 || cyc == 3) begin
               chk("pwrite", PWRITE, fw);
               chk("paddr", PADDR, fa);
               if (fw) chk("pwdata", PWDATA, fd);
            end
         end
         if ((req0_done || req1_done) && lat < 0) lat = cyc;
         if (req0_done) p0 = 0;
         if (req1_done) p1 = 0;
         @(posedge PCLK); #1;
         if (!p0) req0_valid = 0;
         if (!p1) req1_valid = 0;
         cyc++;
      end
      if (p0 || p1) begin
         bound_fail("round_done");
         do_reset(2);
      end
   endtask

   initial begin
      int lat, cyc, bad;
      repeat (3) @(posedge PCLK);
      #1 PRESET = 0;
      @(negedge PCLK);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_done", {req1_done, req0_done}, 0);
      chk("rst_err", {req1_err, req0_err}, 0);
      chk("rst_rdata", {req1_rdata, req0_rdata}, 0);

      run_round(1, 0, 1, TCR_ADDR, 8'hA5, 0, 0, 0, 1, lat);
      chk("latency_write", lat, 4);

      do_reset(1);
      run_round(1, 1, 0, TCR_ADDR, 8'h00, 1, TDR_ADDR, 8'h3C, 0, lat);
      run_round(1, 1, 1, TSR_ADDR, 8'h11, 0, TDR_ADDR, 8'h00, 0, lat);
      run_round(1, 0, 1, TDR_ADDR, 8'h5A, 0, 0, 0, 0, lat);
      run_round(0, 1, 0, 0, 0, 0, TDR_ADDR, 8'h00, 1, lat);
      chk("latency_read", lat, 4);
      run_round(1, 0, 1, 8'h05, 8'h77, 0, 0, 0, 0, lat);
      run_round(1, 0, 0, TSR_ADDR, 8'h00, 0, 0, 0, 0, lat);

      @(posedge PCLK); #1;
      req0_write = 0; req0_addr = TSR_ADDR; req0_valid = 1;
      cyc = 0;
      do begin @(negedge PCLK); cyc++; end while (!PENABLE && cyc < 20);
      if (!PENABLE) bound_fail("reach_access");
      @(posedge PCLK); #1 PRESET = 1; req0_valid = 0;
      @(posedge PCLK); #1 PRESET = 0; ptr_m = 0;
      @(negedge PCLK);
      chk("rstmid_psel", PSEL, 0);
      chk("rstmid_penable", PENABLE, 0);
      chk("rstmid_done", req0_done, 0);
      run_round(1, 1, 1, TCR_ADDR, 8'hC3, 1, TSR_ADDR, 8'h99, 1, lat);
      chk("latency_after_reset", lat, 4);

      rand_waits = 1;
      for (int i = 0; i < 40; i++) begin
         int sel;
         sel = $urandom_range(1, 3);
         run_round(sel[0], sel[1], 1'($urandom), rnd_addr(), 8'($urandom),
                   1'($urandom), rnd_addr(), 8'($urandom), 0, lat);
      end
      rand_waits = 0;

      hold = 1;
`ifdef APB_ARB_TIMEOUT_EN
      exp_q.push_back('{port: 1'b0, rdata: 8'h00, err: 1'b1});
      @(posedge PCLK); #1;
      req0_write = 0; req0_addr = TCR_ADDR; req0_valid = 1;
      cyc = 0;
      while (cyc < 100) begin
         @(negedge PCLK);
         if (req0_done) break;
         cyc++;
      end
      @(posedge PCLK); #1 req0_valid = 0;
      chk("timeout_latency", cyc, 18);
`else
      @(posedge PCLK); #1;
      req0_write = 0; req0_addr = TCR_ADDR; req0_valid = 1;
      repeat (3) @(posedge PCLK);
      bad = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge PCLK);
         if (!(PSEL && PENABLE) || req0_done || req1_done) bad++;
      end
      chk("stall_held", bad, 0);
      do_reset(1);
`endif
      hold = 0;
      repeat (4) @(posedge PCLK);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
